// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU with valid/ready input handshake, a
// one-cycle out_valid pulse, and an iterative multiply/divide unit that writes
// the architectural HI/LO registers.
// Optional build macro ALU_OVERFLOW_EN adds the registered signed-overflow
// output ovf.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             out_valid,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MFHI = 4'b1100;
    localparam logic [3:0] OP_MFLO = 4'b1101;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   zero_q, zero_d;
    logic                   out_valid_q, out_valid_d;
    logic                   illegal_q, illegal_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic [2*WIDTH-1:0]     work_q, work_d;
    logic [WIDTH-1:0]       opb_q, opb_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   is_div_q, is_div_d;
    logic                   qneg_q, qneg_d;
    logic                   rneg_q, rneg_d;
    logic                   divz_q, divz_d;

    logic                   accept;
    logic [WIDTH-1:0]       add_sum, sub_diff;
    logic [WIDTH-1:0]       op_res;
    logic                   op_single, op_ill;
    logic                   md_signed;
    logic [WIDTH-1:0]       a_mag, b_mag;
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_step;
    logic [WIDTH:0]         rem_sh;
    logic                   div_ge;
    logic [WIDTH-1:0]       div_diff;
    logic [2*WIDTH-1:0]     div_step;
    logic [WIDTH-1:0]       fix_hi, fix_lo;

    assign accept    = in_valid && (state_q == S_IDLE);
    assign add_sum   = a + b;
    assign sub_diff  = a - b;
    assign md_signed = ~control[0];
    assign a_mag     = (md_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (md_signed && b[WIDTH-1]) ? -b : b;

    // One shift-add multiply step: multiplier in low half, product grows from the top.
    assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opb_q} : '0);
    assign mul_step = {mul_sum, work_q[WIDTH-1:1]};

    // One restoring-division step: remainder in high half, quotient shifts in at bit 0.
    assign rem_sh   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    assign div_ge   = rem_sh >= {1'b0, opb_q};
    assign div_diff = rem_sh[WIDTH-1:0] - opb_q;
    assign div_step = {(div_ge ? div_diff : rem_sh[WIDTH-1:0]), work_q[WIDTH-2:0], div_ge};

    // Sign fix-up and divide-by-zero override of the raw iterative result.
    always_comb begin
        fix_hi = '0;
        fix_lo = '0;
        if (is_div_q) begin
            if (divz_q) begin
                fix_lo = '1;
                fix_hi = a_q;
            end else begin
                fix_lo = qneg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
                fix_hi = rneg_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
            end
        end else begin
            {fix_hi, fix_lo} = qneg_q ? -work_q : work_q;
        end
    end

    // Single-cycle operation decode.
    always_comb begin
        op_res    = '0;
        op_single = 1'b1;
        op_ill    = 1'b0;
        case (control)
            OP_AND:  op_res = a & b;
            OP_OR:   op_res = a | b;
            OP_ADD:  op_res = add_sum;
            OP_SUB:  op_res = sub_diff;
            OP_XOR:  op_res = a ^ b;
            OP_NOR:  op_res = ~(a | b);
            OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: op_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MFHI: op_res = hi_q;
            OP_MFLO: op_res = lo_q;
            4'b1000, 4'b1001, 4'b1010, 4'b1011: op_single = 1'b0;
            default: op_ill = 1'b1;
        endcase
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        illegal_d   = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        work_d      = work_q;
        opb_d       = opb_q;
        a_d         = a_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        divz_d      = divz_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op_single) begin
                        result_d    = op_res;
                        zero_d      = (op_res == '0);
                        out_valid_d = 1'b1;
                        illegal_d   = op_ill;
                    end else begin
                        state_d  = S_BUSY;
                        cnt_d    = '0;
                        is_div_d = control[1];
                        qneg_d   = md_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_d   = md_signed && a[WIDTH-1];
                        divz_d   = (b == '0);
                        a_d      = a;
                        if (control[1]) begin
                            work_d = {{WIDTH{1'b0}}, a_mag};
                            opb_d  = b_mag;
                        end else begin
                            work_d = {{WIDTH{1'b0}}, b_mag};
                            opb_d  = a_mag;
                        end
                    end
                end
            end
            S_BUSY: begin
                work_d = is_div_q ? div_step : mul_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d        = fix_hi;
                lo_d        = fix_lo;
                result_d    = fix_lo;
                zero_d      = (fix_lo == '0);
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            work_q      <= '0;
            opb_q       <= '0;
            a_q         <= '0;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            divz_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            work_q      <= work_d;
            opb_q       <= opb_d;
            a_q         <= a_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            divz_q      <= divz_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

`ifdef ALU_OVERFLOW_EN
    logic ovf_q, ovf_d;
    logic ovfdiv_q, ovfdiv_d;

    // Signed overflow on ADD/SUB at accept, or on DIV of most-negative by -1 at FIX.
    always_comb begin
        ovf_d    = 1'b0;
        ovfdiv_d = ovfdiv_q;
        if (state_q == S_IDLE && accept) begin
            if (control == OP_ADD) begin
                ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end else if (control == OP_SUB) begin
                ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
            end
            ovfdiv_d = (control == 4'b1010) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        end else if (state_q == S_FIX) begin
            ovf_d = is_div_q && ovfdiv_q;
        end
    end

    // Overflow flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q    <= 1'b0;
            ovfdiv_q <= 1'b0;
        end else begin
            ovf_q    <= ovf_d;
            ovfdiv_q <= ovfdiv_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32), hand-computed vectors.
module tb_alu_seq;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b;
    logic [3:0]    control;
    logic [W-1:0]  result, hi, lo;
    logic          zero, out_valid, illegal;
`ifdef ALU_OVERFLOW_EN
    logic          ovf;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int n_cyc;
    int n_low;
    int n_ov;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .control   (control),
        .result    (result),
        .zero      (zero),
        .out_valid (out_valid),
        .illegal   (illegal),
        .hi        (hi),
        .lo        (lo)
`ifdef ALU_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request at the falling edge; returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        in_valid = 1'b1;
        control  = c;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, and cycles with in_ready low; bounded.
    task automatic wait_done(output int cyc, output int low);
        cyc = 0;
        low = 0;
        while (!out_valid && cyc < 200) begin
            if (!in_ready) low++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; control = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", 64'(result), 64'h0);
        check("rst_zero", 64'(zero), 64'h1);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_hilo", {hi, lo}, 64'h0);
        @(negedge clk); rst = 1'b0;

        // ADD then back-to-back SUB
        issue(4'b0010, 32'd5, 32'd3);
        check("add_valid", 64'(out_valid), 64'h1);
        check("add_result", 64'(result), 64'd8);
        check("add_zero", 64'(zero), 64'h0);
        check("add_illegal", 64'(illegal), 64'h0);
`ifdef ALU_OVERFLOW_EN
        check("add_ovf0", 64'(ovf), 64'h0);
`endif
        issue(4'b0110, 32'd7, 32'd7);
        check("sub_valid", 64'(out_valid), 64'h1);
        check("sub_result", 64'(result), 64'h0);
        check("sub_zero", 64'(zero), 64'h1);
        @(posedge clk); #1;
        check("hold_valid", 64'(out_valid), 64'h0);
        check("hold_zero", 64'(zero), 64'h1);

        issue(4'b0110, 32'd0, 32'd1);
        check("sub_wrap", 64'(result), 64'hFFFF_FFFF);

        // Compares and logic ops
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
        check("slt", 64'(result), 64'd1);
        issue(4'b0101, 32'hFFFF_FFFF, 32'd1);
        check("sltu", 64'(result), 64'd0);
        check("sltu_zero", 64'(zero), 64'h1);
        issue(4'b0000, 32'hF0, 32'h3C);
        check("and", 64'(result), 64'h30);
        issue(4'b0001, 32'hF0, 32'h3C);
        check("or", 64'(result), 64'hFC);
        issue(4'b0011, 32'hF0, 32'h3C);
        check("xor", 64'(result), 64'hCC);
        issue(4'b0100, 32'hF0, 32'h3C);
        check("nor", 64'(result), 64'hFFFF_FF03);

        // MULT -3 * 7
        issue(4'b1000, 32'hFFFF_FFFD, 32'd7);
        wait_done(n_cyc, n_low);
        check("mult_latency", 64'(n_cyc), 64'd33);
        check("mult_busy_cycles", 64'(n_low), 64'd33);
        check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mult_result", 64'(result), 64'hFFFF_FFEB);
        check("mult_ready", 64'(in_ready), 64'h1);
        issue(4'b1100, 32'd0, 32'd0);
        check("mfhi", 64'(result), 64'hFFFF_FFFF);
        check("mfhi_valid", 64'(out_valid), 64'h1);

        // MULTU 0xFFFFFFFF * 2
        issue(4'b1001, 32'hFFFF_FFFF, 32'd2);
        wait_done(n_cyc, n_low);
        check("multu_hilo", {hi, lo}, 64'h1_FFFF_FFFE);
        issue(4'b1101, 32'd0, 32'd0);
        check("mflo", 64'(result), 64'hFFFF_FFFE);

        // Divides
        issue(4'b1011, 32'd100, 32'd7);
        wait_done(n_cyc, n_low);
        check("divu_hilo", {hi, lo}, {32'd2, 32'd14});
        issue(4'b1010, 32'hFFFF_FF9C, 32'd7);
        wait_done(n_cyc, n_low);
        check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFE_FFFF_FFF2);
        issue(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n_cyc, n_low);
        check("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
`ifdef ALU_OVERFLOW_EN
        check("div_ovf_flag", 64'(ovf), 64'h1);
`endif
        issue(4'b1010, 32'd5, 32'd0);
        wait_done(n_cyc, n_low);
        check("div0_latency", 64'(n_cyc), 64'd33);
        check("div0_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        check("div0_zero", 64'(zero), 64'h0);

        // Illegal control code
        issue(4'b1111, 32'd9, 32'd9);
        check("ill_valid", 64'(out_valid), 64'h1);
        check("ill_flag", 64'(illegal), 64'h1);
        check("ill_result", 64'(result), 64'h0);
        check("ill_zero", 64'(zero), 64'h1);
        check("ill_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        @(posedge clk); #1;
        check("ill_pulse_end", 64'(illegal), 64'h0);

`ifdef ALU_OVERFLOW_EN
        issue(4'b0010, 32'h7FFF_FFFF, 32'd1);
        check("add_ovf1", 64'(ovf), 64'h1);
        check("add_ovf_result", 64'(result), 64'h8000_0000);
`endif

        // Reset in the middle of a MULTU
        issue(4'b1001, 32'd12345, 32'd678);
        repeat (9) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", 64'(in_ready), 64'h1);
        check("abort_hilo", {hi, lo}, 64'h0);
        check("abort_out_valid", 64'(out_valid), 64'h0);
        check("abort_zero", 64'(zero), 64'h1);
        @(negedge clk); rst = 1'b0;
        n_ov = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) n_ov++;
        end
        check("abort_no_pulse", 64'(n_ov), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
